// File: rtl/cmpacc_seq.sv
// Template-scan sequencer for the compare accelerator: fetches each stored
// bitmap, loads it into cmpacc, waits (with watchdog) and tracks the best score.
module cmpacc_seq #(
    parameter int NUM_TEMPLATES = 16,
    parameter int IDX_W         = 4,
    parameter int TIMEOUT       = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             mem_rden,
    output logic [IDX_W-1:0] mem_addr,
    input  logic [1535:0]    mem_rdata,
    output logic             acc_wren,
    output logic [1535:0]    acc_bitmap,
    input  logic [12:0]      acc_result,
    input  logic             acc_done,
    output logic [IDX_W-1:0] best_idx,
    output logic [12:0]      best_score,
    output logic             done,
    output logic             timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_GUARD,
        S_WAIT,
        S_NEXT
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TEMPLATES - 1);
    localparam logic [11:0]      WD_LAST  = 12'(TIMEOUT - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [11:0]      r_wdog;
    logic [12:0]      r_score;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_wdog     <= '0;
            r_score    <= '0;
            busy       <= 1'b0;
            mem_rden   <= 1'b0;
            mem_addr   <= '0;
            acc_wren   <= 1'b0;
            acc_bitmap <= '0;
            best_idx   <= '0;
            best_score <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            mem_rden <= 1'b0;
            acc_wren <= 1'b0;
            done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // done is still high on the first IDLE cycle, so a start there is ignored
                    if (start && !done) begin
                        best_idx   <= '0;
                        best_score <= '0;
                        timeout    <= 1'b0;
                        r_idx      <= '0;
                        mem_addr   <= '0;
                        mem_rden   <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    // strobe is registered alongside the bitmap so cmpacc sees both together
                    acc_bitmap <= mem_rdata;
                    acc_wren   <= 1'b1;
                    r_state    <= S_GUARD;
                end
                S_GUARD: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (acc_done) begin
                        r_score <= acc_result;
                        r_state <= S_NEXT;
                    end else begin
                        r_wdog <= r_wdog + 12'd1;
                        if (r_wdog == WD_LAST) begin
                            timeout <= 1'b1;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_NEXT: begin
                    if (r_idx == '0 || r_score > best_score) begin
                        best_idx   <= r_idx;
                        best_score <= r_score;
                    end
                    if (r_idx == LAST_IDX) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx    <= r_idx + 1'b1;
                        mem_addr <= r_idx + 1'b1;
                        mem_rden <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmpacc_seq.sv
// Randomized bench for cmpacc_seq: two instances (4 templates / watchdog 20,
// 16 templates / watchdog 4095) with memory and cmpacc behavioural models.
module tb_cmpacc_seq;

    logic clk = 1'b0;
    logic rst;
    logic clr_log;
    always #5 clk = ~clk;

    logic          start_s  [2];
    logic          busy_s   [2];
    logic          rden_s   [2];
    logic          wren_s   [2];
    logic          done_s   [2];
    logic          tmo_s    [2];
    logic          adone_s  [2];
    logic [3:0]    addr_s   [2];
    logic [3:0]    bidx_s   [2];
    logic [12:0]   res_s    [2];
    logic [12:0]   bscore_s [2];
    logic [1535:0] rdata_s  [2];
    logic [1535:0] bmap_s   [2];

    int unsigned cfg_score [2][16];
    int unsigned cfg_delay [2][16];   // waiting cycles before acc_done; 0 = never completes
    bit          cfg_stale [2][16];   // keep a stale done + junk result through LOAD/GUARD
    logic [31:0] mem_seed  [2];

    int          wren_cnt  [2];
    int          rden_cnt  [2];
    int          bmap_err  [2];
    logic [3:0]  addr_log  [2][64];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [1535:0] pattern(input logic [3:0] a, input logic [31:0] seed);
        logic [1535:0] p;
        for (int i = 0; i < 48; i++)
            p[i*32 +: 32] = seed ^ 32'(32'h9E3779B9 * (i + 1)) ^ {28'h0, a};
        return p;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        cmpacc_seq #(
            .NUM_TEMPLATES(g == 0 ? 4 : 16),
            .IDX_W(4),
            .TIMEOUT(g == 0 ? 20 : 4095)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_s[g]),
            .busy      (busy_s[g]),
            .mem_rden  (rden_s[g]),
            .mem_addr  (addr_s[g]),
            .mem_rdata (rdata_s[g]),
            .acc_wren  (wren_s[g]),
            .acc_bitmap(bmap_s[g]),
            .acc_result(res_s[g]),
            .acc_done  (adone_s[g]),
            .best_idx  (bidx_s[g]),
            .best_score(bscore_s[g]),
            .done      (done_s[g]),
            .timeout   (tmo_s[g])
        );

        logic [3:0] m_cur;
        int         m_cnt;

        always @(posedge clk) begin
            if (rden_s[g]) begin
                rdata_s[g] <= pattern(addr_s[g], mem_seed[g]);
                m_cur      <= addr_s[g];
            end
            if (clr_log) begin
                wren_cnt[g] <= 0;
                rden_cnt[g] <= 0;
                bmap_err[g] <= 0;
            end else begin
                if (rden_s[g]) begin
                    if (rden_cnt[g] < 64) addr_log[g][rden_cnt[g]] <= addr_s[g];
                    rden_cnt[g] <= rden_cnt[g] + 1;
                end
                if (wren_s[g]) begin
                    wren_cnt[g] <= wren_cnt[g] + 1;
                    if (bmap_s[g] !== pattern(m_cur, mem_seed[g])) bmap_err[g] <= bmap_err[g] + 1;
                end
            end
            if (rst) begin
                adone_s[g] <= 1'b0;
                res_s[g]   <= '0;
                m_cnt      <= 0;
            end else if (wren_s[g]) begin
                adone_s[g] <= 1'b0;
                res_s[g]   <= 13'h1FFF;
                m_cnt      <= int'(cfg_delay[g][m_cur]);
            end else if (rden_s[g]) begin
                if (cfg_stale[g][addr_s[g]]) res_s[g] <= 13'h1FFF;
                else adone_s[g] <= 1'b0;
            end else if (m_cnt == 1) begin
                adone_s[g] <= 1'b1;
                res_s[g]   <= 13'(cfg_score[g][m_cur]);
                m_cnt      <= 0;
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Expected outcome from the configured scores/delays: best is the maximum
    // score, earliest index among equals, over templates completed before any hang.
    task automatic ref_model(input int u, input int n, output int e_idx, output int e_score,
                             output int e_cyc, output int e_tmo, output int k);
        int mx, base;
        k = n;
        for (int i = n - 1; i >= 0; i--) if (cfg_delay[u][i] == 0) k = i;
        mx = 0; base = 0;
        for (int i = 0; i < k; i++) begin
            if (int'(cfg_score[u][i]) > mx) mx = int'(cfg_score[u][i]);
            base += int'(cfg_delay[u][i]) + 5;
        end
        e_idx = 0;
        for (int i = k - 1; i >= 0; i--) if (int'(cfg_score[u][i]) == mx) e_idx = i;
        e_score = mx;
        e_tmo   = (k < n) ? 1 : 0;
        e_cyc   = (k < n) ? base + 3 + (u == 0 ? 20 : 4095) + 1 : base + 1;
    endtask

    task automatic scan_and_compare(input string tag, input int u, input int n);
        int e_idx, e_score, e_cyc, e_tmo, k, cyc, busy_low, addr_bad, loads;
        ref_model(u, n, e_idx, e_score, e_cyc, e_tmo, k);
        mem_seed[u] = $urandom;
        clr_log = 1'b1;
        @(negedge clk);
        clr_log = 1'b0;
        start_s[u] = 1'b1;
        @(negedge clk);
        start_s[u] = 1'b0;
        cyc = 1; busy_low = 0;
        while (done_s[u] !== 1'b1 && cyc < 6000) begin
            if (busy_s[u] !== 1'b1) busy_low++;
            @(negedge clk);
            cyc++;
        end
        loads = e_tmo ? k + 1 : n;
        addr_bad = 0;
        for (int i = 0; i < rden_cnt[u] && i < 64; i++) if (addr_log[u][i] !== 4'(i)) addr_bad++;
        n_checks++; if (cyc !== e_cyc) begin n_fail++; $display("FAIL %s done_cycle got=%0d exp=%0d", tag, cyc, e_cyc); end
        n_checks++; if (int'(bidx_s[u]) !== e_idx) begin n_fail++; $display("FAIL %s best_idx got=%0d exp=%0d", tag, bidx_s[u], e_idx); end
        n_checks++; if (int'(bscore_s[u]) !== e_score) begin n_fail++; $display("FAIL %s best_score got=%0d exp=%0d", tag, bscore_s[u], e_score); end
        n_checks++; if (int'(tmo_s[u]) !== e_tmo) begin n_fail++; $display("FAIL %s timeout got=%0d exp=%0d", tag, tmo_s[u], e_tmo); end
        n_checks++; if (busy_s[u] !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done got=%b exp=0", tag, busy_s[u]); end
        n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL %s busy_low_cycles got=%0d exp=0", tag, busy_low); end
        n_checks++; if (wren_cnt[u] !== loads) begin n_fail++; $display("FAIL %s wren_pulses got=%0d exp=%0d", tag, wren_cnt[u], loads); end
        n_checks++; if (rden_cnt[u] !== loads) begin n_fail++; $display("FAIL %s rden_pulses got=%0d exp=%0d", tag, rden_cnt[u], loads); end
        n_checks++; if (addr_bad !== 0) begin n_fail++; $display("FAIL %s addr_sequence bad=%0d exp=0", tag, addr_bad); end
        n_checks++; if (bmap_err[u] !== 0) begin n_fail++; $display("FAIL %s bitmap_at_wren bad=%0d exp=0", tag, bmap_err[u]); end
    endtask

    task automatic fill(input int u, input int lo, input int hi, input int dlo, input int dhi);
        for (int i = 0; i < 16; i++) begin
            cfg_score[u][i] = $urandom_range(hi, lo);
            cfg_delay[u][i] = $urandom_range(dhi, dlo);
            cfg_stale[u][i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if ({busy_s[u], rden_s[u], wren_s[u], done_s[u], tmo_s[u]} !== 5'b0 ||
                addr_s[u] !== 4'd0 || bidx_s[u] !== 4'd0 || bscore_s[u] !== 13'd0 || bmap_s[u] !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs u%0d busy=%b rden=%b wren=%b done=%b tmo=%b addr=%0d bidx=%0d bscore=%0d bmap_nonzero=%b exp all 0",
                         u, busy_s[u], rden_s[u], wren_s[u], done_s[u], tmo_s[u], addr_s[u], bidx_s[u], bscore_s[u], bmap_s[u] != '0);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int sc[4] = '{100, 900, 900, 300};
        fill(0, 0, 0, 10, 10);
        for (int i = 0; i < 4; i++) cfg_score[0][i] = sc[i];
        scan_and_compare("basic_tie", 0, 4);
    endtask

    task automatic test_stale();
        fill(0, 0, 0, 3, 9);
        cfg_score[0][0] = 10; cfg_score[0][1] = 20; cfg_score[0][2] = 30; cfg_score[0][3] = 5;
        cfg_stale[0][2] = 1'b1;
        scan_and_compare("stale_done", 0, 4);
        cfg_stale[0][2] = 1'b0;
    endtask

    task automatic test_timeout();
        fill(0, 0, 8191, 1, 15);
        cfg_delay[0][2] = 0;
        scan_and_compare("timeout", 0, 4);
        fill(0, 0, 8191, 1, 15);
        scan_and_compare("timeout_cleared", 0, 4);
        fill(0, 0, 8191, 1, 15);
        cfg_delay[0][0] = 0;
        scan_and_compare("timeout_first", 0, 4);
    endtask

    task automatic test_all_zero();
        fill(0, 0, 0, 1, 6);
        scan_and_compare("all_zero", 0, 4);
    endtask

    task automatic test_random16();
        for (int r = 0; r < 3; r++) begin
            fill(1, 0, 8191, 1, 12);
            cfg_score[1][$urandom_range(15, 8)] = cfg_score[1][$urandom_range(7, 0)];
            scan_and_compare("random16", 1, 16);
        end
        fill(1, 0, 8191, 1, 4);
        cfg_score[1][15] = 8191;
        scan_and_compare("max_last16", 1, 16);
    endtask

    task automatic test_back_to_back();
        fill(1, 7000, 8000, 1, 5);
        scan_and_compare("b2b_first", 1, 16);
        fill(1, 0, 50, 1, 5);
        scan_and_compare("b2b_second", 1, 16);
    endtask

    task automatic test_start_on_done();
        int t;
        fill(1, 0, 8191, 1, 3);
        scan_and_compare("pre_done_start", 1, 16);
        start_s[1] = 1'b1;
        @(negedge clk);
        n_checks++; if (busy_s[1] !== 1'b0) begin n_fail++; $display("FAIL start_on_done_ignored busy got=%b exp=0", busy_s[1]); end
        @(negedge clk);
        start_s[1] = 1'b0;
        n_checks++; if (busy_s[1] !== 1'b1) begin n_fail++; $display("FAIL start_after_done_accepted busy got=%b exp=1", busy_s[1]); end
        t = 0;
        while (done_s[1] !== 1'b1 && t < 6000) begin @(negedge clk); t++; end
        n_checks++; if (done_s[1] !== 1'b1) begin n_fail++; $display("FAIL start_after_done_completes done got=%b exp=1", done_s[1]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int t, dones;
        fill(1, 0, 8191, 8, 8);
        clr_log = 1'b1;
        @(negedge clk);
        clr_log = 1'b0;
        start_s[1] = 1'b1;
        @(negedge clk);
        start_s[1] = 1'b0;
        t = 0;
        while (wren_cnt[1] < 6 && t < 2000) begin @(negedge clk); t++; end
        n_checks++; if (wren_cnt[1] !== 6) begin n_fail++; $display("FAIL reset_mid_reach_t5 wren got=%0d exp=6", wren_cnt[1]); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy_s[1], rden_s[1], wren_s[1], done_s[1], tmo_s[1]} !== 5'b0 ||
            addr_s[1] !== 4'd0 || bidx_s[1] !== 4'd0 || bscore_s[1] !== 13'd0 || bmap_s[1] !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs busy=%b rden=%b wren=%b done=%b tmo=%b addr=%0d bidx=%0d bscore=%0d exp all 0",
                     busy_s[1], rden_s[1], wren_s[1], done_s[1], tmo_s[1], addr_s[1], bidx_s[1], bscore_s[1]);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_s[1] === 1'b1 || wren_s[1] === 1'b1 || busy_s[1] !== 1'b0) dones++;
            @(negedge clk);
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL reset_mid_quiet activity_cycles got=%0d exp=0", dones); end
        scan_and_compare("after_reset", 1, 16);
    endtask

    initial begin
        rst = 1'b1; clr_log = 1'b0;
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        mem_seed[0] = '0; mem_seed[1] = '0;
        for (int u = 0; u < 2; u++) fill(u, 0, 0, 1, 1);
        @(negedge clk);
        test_reset();
        test_basic();
        test_stale();
        test_timeout();
        test_all_zero();
        test_random16();
        test_back_to_back();
        test_start_on_done();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
